ip_packet_tx: RTL

Transmit-side packet builder for the accelerator's network path. It accepts one inference result per handshake and wraps it in an Ethernet header and an IPv4 header, including a computed header checksum. It then streams the frame byte-by-byte to the MAC's AXI-Stream slave port. The MAC appends padding and FCS.

---
 rtl/ip_packet_tx.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ip_packet_tx.sv
// Transmit-side packet builder: wraps one inference result in Ethernet + IPv4
// headers (with computed header checksum) and streams it byte-wise to the MAC.
`timescale 1ns/1ps
module ip_packet_tx #(
  parameter int          PAYLOAD_BYTES = 2,
  parameter logic [7:0]  IP_PROTOCOL   = 8'hFD,
  parameter logic [7:0]  IP_TTL        = 8'h40
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [31:0]                ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]                ACCELERATOR_MAC_ADDRESS,
  input  logic                       TX_VALID,
  output logic                       TX_READY,
  input  logic [31:0]                DST_IP_ADDRESS,
  input  logic [47:0]                DST_MAC_ADDRESS,
  input  logic [PAYLOAD_BYTES*8-1:0] RESULT_DATA,
  output logic                       TX_DONE,
  output logic [7:0]                 MAC_DATA_IN,
  output logic                       MAC_DATA_VALID,
  input  logic                       MAC_DATA_READY,
  output logic                       MAC_DATA_LAST
);

  localparam int         PW        = PAYLOAD_BYTES * 8;
  localparam logic [15:0] TOTAL_LEN = 16'(24 + PAYLOAD_BYTES);
  localparam logic [15:0] CSUM_LAST = 16'd11;
  localparam logic [15:0] ETH_LAST  = 16'd13;
  localparam logic [15:0] IP_LAST   = 16'd23;
  localparam logic [15:0] PAY_LAST  = 16'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    SEND_ETH_HDR,
    SEND_IP_HDR,
    SEND_PAYLOAD
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [19:0]     sum_q, sum_d;
  logic [15:0]     csum_q, csum_d;
  logic [15:0]     pkt_id_q, pkt_id_d;
  logic [31:0]     dst_ip_q, dst_ip_d;
  logic [47:0]     dst_mac_q, dst_mac_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            beat;

  function automatic logic [7:0] eth_byte(input int idx, input logic [47:0] dmac,
                                          input logic [47:0] smac);
    logic [111:0] hdr;
    hdr = {dmac, smac, 8'h08, 8'h00};
    return 8'(hdr >> (8 * (13 - idx)));
  endfunction

  function automatic logic [7:0] ip_byte(input int idx, input logic [15:0] id,
                                         input logic [15:0] csum, input logic [31:0] sip,
                                         input logic [31:0] dip);
    logic [191:0] hdr;
    hdr = {8'h46, 8'h00, TOTAL_LEN, id, 16'h4000, IP_TTL, IP_PROTOCOL, csum, sip, dip, 32'h0};
    return 8'(hdr >> (8 * (23 - idx)));
  endfunction

  function automatic logic [7:0] pay_byte(input int idx, input logic [PW-1:0] p);
    return 8'(p >> (8 * idx));
  endfunction

  // End-around carry folded twice; 12 words can never need a third fold.
  function automatic logic [15:0] fold_csum(input logic [19:0] s);
    logic [19:0] f;
    f = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    f = {4'h0, f[15:0]} + {16'h0, f[19:16]};
    return ~f[15:0];
  endfunction

  assign beat = valid_q && MAC_DATA_READY;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    csum_d    = csum_q;
    pkt_id_d  = pkt_id_q;
    dst_ip_d  = dst_ip_q;
    dst_mac_d = dst_mac_q;
    payload_d = payload_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (TX_VALID) begin
          dst_ip_d  = DST_IP_ADDRESS;
          dst_mac_d = DST_MAC_ADDRESS;
          payload_d = RESULT_DATA;
          sum_d     = '0;
          cnt_d     = '0;
          ready_d   = 1'b0;
          state_d   = CSUM;
        end
      end
      // Header words are rebuilt from the byte view with the checksum field zeroed.
      CSUM: begin
        sum_d = sum_q + {4'h0,
                         ip_byte(2 * int'(cnt_q), pkt_id_q, 16'h0000,
                                 ACCELERATOR_IP_ADDRESS, dst_ip_q),
                         ip_byte(2 * int'(cnt_q) + 1, pkt_id_q, 16'h0000,
                                 ACCELERATOR_IP_ADDRESS, dst_ip_q)};
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == CSUM_LAST) begin
          csum_d  = fold_csum(sum_d);
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = eth_byte(0, dst_mac_q, ACCELERATOR_MAC_ADDRESS);
          state_d = SEND_ETH_HDR;
        end
      end
      SEND_ETH_HDR: begin
        if (beat) begin
          if (cnt_q == ETH_LAST) begin
            cnt_d   = '0;
            data_d  = ip_byte(0, pkt_id_q, csum_q, ACCELERATOR_IP_ADDRESS, dst_ip_q);
            state_d = SEND_IP_HDR;
          end else begin
            cnt_d  = cnt_q + 16'd1;
            data_d = eth_byte(int'(cnt_q) + 1, dst_mac_q, ACCELERATOR_MAC_ADDRESS);
          end
        end
      end
      SEND_IP_HDR: begin
        if (beat) begin
          if (cnt_q == IP_LAST) begin
            cnt_d   = '0;
            data_d  = pay_byte(0, payload_q);
            last_d  = (PAY_LAST == 16'd0);
            state_d = SEND_PAYLOAD;
          end else begin
            cnt_d  = cnt_q + 16'd1;
            data_d = ip_byte(int'(cnt_q) + 1, pkt_id_q, csum_q, ACCELERATOR_IP_ADDRESS,
                             dst_ip_q);
          end
        end
      end
      SEND_PAYLOAD: begin
        if (beat) begin
          if (cnt_q == PAY_LAST) begin
            cnt_d    = '0;
            valid_d  = 1'b0;
            data_d   = 8'h00;
            last_d   = 1'b0;
            done_d   = 1'b1;
            ready_d  = 1'b1;
            pkt_id_d = pkt_id_q + 16'd1;
            state_d  = IDLE;
          end else begin
            cnt_d  = cnt_q + 16'd1;
            data_d = pay_byte(int'(cnt_q) + 1, payload_q);
            last_d = ((cnt_q + 16'd1) == PAY_LAST);
          end
        end
      end
      default: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      csum_q    <= '0;
      pkt_id_q  <= '0;
      dst_ip_q  <= '0;
      dst_mac_q <= '0;
      payload_q <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      csum_q    <= csum_d;
      pkt_id_q  <= pkt_id_d;
      dst_ip_q  <= dst_ip_d;
      dst_mac_q <= dst_mac_d;
      payload_q <= payload_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign TX_READY       = ready_q;
  assign TX_DONE        = done_q;
  assign MAC_DATA_IN    = data_q;
  assign MAC_DATA_VALID = valid_q;
  assign MAC_DATA_LAST  = last_q;

endmodule
